serial_add_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single 1-bit full-adder cell (`full_adder`: a, b, cin -> sum, cout) to add two WIDTH-bit operands over WIDTH clock cycles, LSB first. It sits between an operand producer and a result consumer, each with a valid/ready handshake. It holds all operand, result and carry state, so the instantiated `full_adder` stays purely combinational.

---
 rtl/serial_add_ctrl.sv | 145 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder controller. It accepts two WIDTH-bit operands plus a
//   carry-in, then adds them one bit per clock (LSB first) through a single
//   combinational full_adder cell. The result is presented on a valid/ready
//   output port.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. The producer side (in_valid/in_ready) is only ready in IDLE.
//   The consumer side (out_valid/out_ready) is only valid in DONE. The two
//   sides never complete on the same edge.
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   synchronous active-low reset
//     in_valid   in   operands valid
//     in_ready   out  controller can accept operands (IDLE)
//     op_a       in   operand A [WIDTH]
//     op_b       in   operand B [WIDTH]
//     cin_in     in   initial carry-in
//     out_valid  out  result valid (DONE)
//     out_ready  in   consumer accepts result
//     sum        out  op_a + op_b + cin_in mod 2^WIDTH [WIDTH]
//     cout       out  carry out of the MSB
//     ovf        out  two's-complement overflow
//     busy       out  high in RUN or DONE

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] s_sr_q;
    logic [WIDTH-1:0] s_sr_d;
    logic             carry_q;
    logic             c_msb_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             last_bit;

    logic fa_sum;
    logic fa_cout;

    full_adder fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 of the
    // result sits at bit 0 of the register.
    assign s_sr_d   = {fa_sum, s_sr_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_q  <= op_a;
                        b_sr_q  <= op_b;
                        carry_q <= cin_in;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s_sr_q  <= s_sr_d;
                    carry_q <= fa_cout;
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // carry_q here is the carry into the MSB. The result
                        // is copied to hold registers so it survives the shift
                        // registers being reused by the next operation.
                        c_msb_q <= carry_q;
                        sum_q   <= s_sr_d;
                        cout_q  <= fa_cout;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = c_msb_q ^ cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  localparam int W  = 8;
  localparam int W4 = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT (WIDTH = 8) ----------------
  logic         in_valid, in_ready, cin_in, out_valid, out_ready, cout, ovf, busy;
  logic [W-1:0] op_a, op_b, sum;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin_in    (cin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  // ---------------- DUT (WIDTH = 4) ----------------
  logic          in_valid4, in_ready4, cin_in4, out_valid4, out_ready4, cout4, ovf4, busy4;
  logic [W4-1:0] op_a4, op_b4, sum4;

  serial_add_ctrl #(.WIDTH(W4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .op_a      (op_a4),
    .op_b      (op_b4),
    .cin_in    (cin_in4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4),
    .ovf       (ovf4),
    .busy      (busy4)
  );

  // ---------------- scoreboard ----------------
  // Entries are {cout, ovf, sum}.
  logic [W+1:0]  exp_q[$];
  logic [W4+1:0] exp4_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {8'd0, c};
    v = (a[7] == b[7]) && (s[7] != a[7]);
    return {s[8], v, s[7:0]};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {4'd0, c};
    v = (a[3] == b[3]) && (s[3] != a[3]);
    return {s[4], v, s[3:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // One complete operation with out_ready held high; checks latency and result.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c, input string name);
    logic [9:0] want;
    int lat;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    cin_in    = c;
    out_ready = 1'b1;
    exp_q.push_back(model8(a, b, c));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != W) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d edges want %0d", name, lat, W);
    end
    if (out_valid === 1'b1 && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_checks++;
      if ({cout, ovf, sum} !== want) begin
        n_fail++;
        $display("FAIL %s_result: got cout=%b ovf=%b sum=%h want cout=%b ovf=%b sum=%h",
                 name, cout, ovf, sum, want[9], want[8], want[7:0]);
      end
    end else begin
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    op_a       = 8'hFF;
    op_b       = 8'h01;
    cin_in     = 1'b1;
    out_ready  = 1'b0;
    in_valid4  = 1'b0;
    op_a4      = '0;
    op_b4      = '0;
    cin_in4    = 1'b0;
    out_ready4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (sum !== 8'h00)      begin n_fail++; $display("FAIL reset_sum: got %h want 00", sum); end
    n_checks++;
    if (cout !== 1'b0)      begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
    n_checks++;
    if (ovf !== 1'b0)       begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_checks++;
    if (busy4 !== 1'b0 || in_ready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_dut4: got busy=%b in_ready=%b want 0 1", busy4, in_ready4);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: got busy=%b want 0", busy); end
  endtask

  task automatic test_basic();
    run_op8(8'h3A, 8'h45, 1'b0, "basic");
  endtask

  task automatic test_corners();
    logic [7:0] ta[4];
    logic [7:0] tb[4];
    logic       tc[4];
    ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0;
    ta[1] = 8'h7F; tb[1] = 8'h01; tc[1] = 1'b0;
    ta[2] = 8'h80; tb[2] = 8'h80; tc[2] = 1'b0;
    ta[3] = 8'hFF; tb[3] = 8'hFF; tc[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op8(ta[i], tb[i], tc[i], $sformatf("corner%0d", i));
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] want;
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    op_a      = 8'h3A;
    op_b      = 8'h45;
    cin_in    = 1'b0;
    out_ready = 1'b0;
    exp_q.push_back(model8(8'h3A, 8'h45, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != W) begin n_fail++; $display("FAIL bp_latency: got %0d edges want %0d", lat, W); end
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op_a     = 8'($urandom_range(0, 255));
      op_b     = 8'($urandom_range(0, 255));
      cin_in   = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, out_valid); end
      n_checks++;
      if ({cout, ovf, sum} !== want) begin
        n_fail++;
        $display("FAIL bp_hold_result%0d: got %b_%b_%h want %b_%b_%h", i, cout, ovf, sum, want[9], want[8], want[7:0]);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    n_checks++;
    if (sum !== want[7:0])  begin n_fail++; $display("FAIL bp_sum_held: got %h want %h", sum, want[7:0]); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    in_valid  = 1'b1;
    op_a      = 8'hAA;
    op_b      = 8'h55;
    cin_in    = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_idle: got busy=%b in_ready=%b out_valid=%b want 0 1 0", busy, in_ready, out_valid);
    end
    n_checks++;
    if (sum !== 8'h00) begin n_fail++; $display("FAIL midrun_sum_cleared: got %h want 00", sum); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL midrun_no_result: got %0d valid cycles want 0", seen); end
    run_op8(8'h10, 8'h20, 1'b0, "after_reset");
  endtask

  task automatic test_stream8();
    logic [9:0] want;
    logic [7:0] a, b;
    logic       c;
    int acc, got, cyc, last_acc;
    acc = 0; got = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1;
    while ((acc < 1000 || got < 1000) && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream8_extra: unexpected result sum=%h", sum);
        end else begin
          want = exp_q.pop_front();
          if ({cout, ovf, sum} !== want) begin
            n_fail++;
            $display("FAIL stream8_result%0d: got %b_%b_%h want %b_%b_%h", got, cout, ovf, sum, want[9], want[8], want[7:0]);
          end
        end
        got++;
      end
      if (in_ready === 1'b1) begin
        if (acc < 1000) begin
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
          c = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          op_a = a;
          op_b = b;
          cin_in = c;
          exp_q.push_back(model8(a, b, c));
          if (last_acc >= 0) begin
            n_checks++;
            if (cyc - last_acc != W + 2) begin
              n_fail++;
              $display("FAIL stream8_interval: got %0d want %0d", cyc - last_acc, W + 2);
            end
          end
          last_acc = cyc;
          acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != 1000) begin n_fail++; $display("FAIL stream8_count: got %0d results want 1000", got); end
  endtask

  task automatic test_exhaustive4();
    logic [5:0] want;
    logic [8:0] k;
    int acc, got, cyc, last_acc;
    acc = 0; got = 0; cyc = 0; last_acc = -1;
    out_ready4 = 1'b1;
    while ((acc < 512 || got < 512) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (out_valid4 === 1'b1) begin
        n_checks++;
        if (exp4_q.size() == 0) begin
          n_fail++;
          $display("FAIL exh4_extra: unexpected result sum=%h", sum4);
        end else begin
          want = exp4_q.pop_front();
          if ({cout4, ovf4, sum4} !== want) begin
            n_fail++;
            $display("FAIL exh4_result%0d: got %b_%b_%h want %b_%b_%h", got, cout4, ovf4, sum4, want[5], want[4], want[3:0]);
          end
        end
        got++;
      end
      if (in_ready4 === 1'b1) begin
        if (acc < 512) begin
          k = 9'(acc);
          in_valid4 = 1'b1;
          op_a4 = k[3:0];
          op_b4 = k[7:4];
          cin_in4 = k[8];
          exp4_q.push_back(model4(k[3:0], k[7:4], k[8]));
          if (last_acc >= 0) begin
            n_checks++;
            if (cyc - last_acc != W4 + 2) begin
              n_fail++;
              $display("FAIL exh4_interval: got %0d want %0d", cyc - last_acc, W4 + 2);
            end
          end
          last_acc = cyc;
          acc++;
        end else begin
          in_valid4 = 1'b0;
        end
      end
    end
    in_valid4 = 1'b0;
    n_checks++;
    if (got != 512) begin n_fail++; $display("FAIL exh4_count: got %0d results want 512", got); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid_run();
    test_stream8();
    test_exhaustive4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
